// File: rtl/melody_pkg.sv
// Shared types, note-code constants and the default melody table for the melody sequencer.
package melody_pkg;

  localparam int unsigned MELODY_LEN = 20;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned DUR_W      = 4;
  localparam int unsigned PITCH_W    = 5;
  localparam int unsigned IDX_W      = 5;

  typedef logic [CODE_W-1:0]  note_code_t;
  typedef logic [DUR_W-1:0]   dur_t;
  typedef logic [PITCH_W-1:0] pitch_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef struct packed {
    note_code_t code;
    dur_t       dur;
  } note_entry_t;

  typedef note_entry_t [0:MELODY_LEN-1] melody_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam note_code_t NOTE_D     = 4'd0;
  localparam note_code_t NOTE_E     = 4'd1;
  localparam note_code_t NOTE_FIS   = 4'd2;
  localparam note_code_t NOTE_G     = 4'd3;
  localparam note_code_t NOTE_A     = 4'd4;
  localparam note_code_t NOTE_B     = 4'd5;
  localparam note_code_t NOTE_C     = 4'd6;
  localparam note_code_t NOTE_DHIGH = 4'd7;
  localparam note_code_t NOTE_REST  = 4'd8;

  // Every code from REST upward is silent.
  function automatic logic is_rest_code(input note_code_t code);
    return (code >= NOTE_REST);
  endfunction

  function automatic pitch_t code_to_maxval(input note_code_t code);
    pitch_t m;
    m = '0;
    case (code)
      NOTE_D:     m = 5'd27;
      NOTE_E:     m = 5'd24;
      NOTE_FIS:   m = 5'd21;
      NOTE_G:     m = 5'd20;
      NOTE_A:     m = 5'd18;
      NOTE_B:     m = 5'd16;
      NOTE_C:     m = 5'd15;
      NOTE_DHIGH: m = 5'd13;
      default:    m = '0;
    endcase
    return m;
  endfunction

  localparam melody_t DEFAULT_MELODY = '{
    '{NOTE_D,     4'd4}, '{NOTE_G,     4'd4}, '{NOTE_G,     4'd2}, '{NOTE_A,     4'd2},
    '{NOTE_B,     4'd4}, '{NOTE_G,     4'd4}, '{NOTE_DHIGH, 4'd8}, '{NOTE_B,     4'd6},
    '{NOTE_B,     4'd2}, '{NOTE_C,     4'd4}, '{NOTE_DHIGH, 4'd2}, '{NOTE_C,     4'd2},
    '{NOTE_B,     4'd2}, '{NOTE_C,     4'd2}, '{NOTE_DHIGH, 4'd4}, '{NOTE_A,     4'd2},
    '{NOTE_G,     4'd2}, '{NOTE_A,     4'd2}, '{NOTE_B,     4'd2}, '{NOTE_A,     4'd4}
  };

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a playback controller and the melody sequencer.
interface melody_sequencer_if;
  import melody_pkg::*;

  logic   start;
  logic   stop;
  logic   loop_en;
  pitch_t pitch_maxval;
  logic   tone_en;
  idx_t   note_idx;
  logic   note_start;
  logic   busy;
  logic   done;

  modport master (
    output start, stop, loop_en,
    input  pitch_maxval, tone_en, note_idx, note_start, busy, done
  );

  modport slave (
    input  start, stop, loop_en,
    output pitch_maxval, tone_en, note_idx, note_start, busy, done
  );

endinterface

// File: rtl/melody_rom.sv
// Combinational melody table lookup: index -> divider value, rest flag, duration (0 clamped to 1).
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned N_NOTES = MELODY_LEN,
  parameter note_entry_t [0:N_NOTES-1] MELODY = DEFAULT_MELODY
) (
  input  idx_t   idx_i,
  output pitch_t pitch_maxval_c_o,
  output logic   is_rest_c_o,
  output dur_t   dur_units_c_o
);

  note_entry_t entry_c;

  always_comb begin
    entry_c = MELODY[0];
    if (32'(idx_i) < N_NOTES) begin
      entry_c = MELODY[idx_i];
    end
  end

  assign pitch_maxval_c_o = code_to_maxval(entry_c.code);
  assign is_rest_c_o      = is_rest_code(entry_c.code);
  assign dur_units_c_o    = (entry_c.dur == '0) ? DUR_W'(1) : entry_c.dur;

endmodule

// File: rtl/melody_sequencer.sv
// Tempo-timed melody sequencer: walks the note table and drives the sine divider value and tone gate.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned N_NOTES      = MELODY_LEN,
  parameter int unsigned TICK_MAXVAL  = 125,
  parameter int unsigned UNIT_SAMPLES = 2000,
  parameter int unsigned GAP_SAMPLES  = 200,
  parameter int unsigned CNT_W        = 14,
  parameter note_entry_t [0:N_NOTES-1] MELODY = DEFAULT_MELODY
) (
  input  logic clk,
  input  logic reset,
  melody_sequencer_if.slave seq
);

  localparam int unsigned TICK_W = (TICK_MAXVAL > 1) ? $clog2(TICK_MAXVAL) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAXVAL - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);
  localparam idx_t              LAST_IDX  = IDX_W'(N_NOTES - 1);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  idx_t              idx_q, idx_d;
  pitch_t            pitch_q, pitch_d;
  logic              tone_q, tone_d;
  logic              nstart_q, nstart_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  dur_t              dur_q, dur_d;
  logic              rest_q, rest_d;

  logic              tick_c;
  logic              last_note_c;
  logic              load_c;
  idx_t              next_idx_c;
  idx_t              rom_idx_c;
  logic [CNT_W-1:0]  play_last_c;
  pitch_t            rom_pitch_c;
  logic              rom_rest_c;
  dur_t              rom_dur_c;

  assign tick_c      = (state_q != ST_IDLE) && (div_q == TICK_LAST);
  assign last_note_c = (idx_q == LAST_IDX);
  assign next_idx_c  = last_note_c ? '0 : idx_q + IDX_W'(1);
  assign rom_idx_c   = (state_q == ST_IDLE) ? '0 : next_idx_c;
  // Sounding part of a note ends GAP_SAMPLES before its full length.
  assign play_last_c = CNT_W'(32'(dur_q) * UNIT_SAMPLES - GAP_SAMPLES - 1);

  melody_rom #(
    .N_NOTES (N_NOTES),
    .MELODY  (MELODY)
  ) u_rom (
    .idx_i            (rom_idx_c),
    .pitch_maxval_c_o (rom_pitch_c),
    .is_rest_c_o      (rom_rest_c),
    .dur_units_c_o    (rom_dur_c)
  );

  // Sample-tick divider: free-runs while busy, held at zero in IDLE.
  always_comb begin
    div_d = '0;
    if ((state_q != ST_IDLE) && !seq.stop) begin
      div_d = tick_c ? '0 : div_q + TICK_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pitch_d  = pitch_q;
    tone_d   = tone_q;
    nstart_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dur_d    = dur_q;
    rest_d   = rest_q;
    load_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tone_d = 1'b0;
        busy_d = 1'b0;
        idx_d  = '0;
        cnt_d  = '0;
        if (seq.start && !seq.stop) begin
          state_d = ST_PLAY;
          load_c  = 1'b1;
        end
      end

      ST_PLAY: begin
        if (seq.stop) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          if (cnt_q == play_last_c) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            tone_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (seq.stop) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          if (cnt_q == GAP_LAST) begin
            if (!last_note_c || seq.loop_en) begin
              state_d = ST_PLAY;
              load_c  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              idx_d   = '0;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: silence and rewind immediately, no done pulse.
    if ((state_q != ST_IDLE) && seq.stop) begin
      tone_d = 1'b0;
      busy_d = 1'b0;
      idx_d  = '0;
      cnt_d  = '0;
    end

    if (load_c) begin
      idx_d    = rom_idx_c;
      cnt_d    = '0;
      nstart_d = 1'b1;
      busy_d   = 1'b1;
      dur_d    = rom_dur_c;
      rest_d   = rom_rest_c;
      tone_d   = !rom_rest_c;
      if (!rom_rest_c) begin
        pitch_d = rom_pitch_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      pitch_q  <= '0;
      tone_q   <= 1'b0;
      nstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dur_q    <= '0;
      rest_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pitch_q  <= pitch_d;
      tone_q   <= tone_d;
      nstart_q <= nstart_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dur_q    <= dur_d;
      rest_q   <= rest_d;
    end
  end

  assign seq.pitch_maxval = pitch_q;
  assign seq.tone_en      = tone_q;
  assign seq.note_idx     = idx_q;
  assign seq.note_start   = nstart_q;
  assign seq.busy         = busy_q;
  assign seq.done         = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a fast tempo (4 clk/tick, 2 ticks/unit, 1-tick gap).
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int unsigned TICK = 4;
  localparam int unsigned UNIT = 2;
  localparam int unsigned GAP  = 1;

  function automatic melody_t make_rest_melody();
    melody_t m;
    m = DEFAULT_MELODY;
    m[2] = '{code: NOTE_REST, dur: 4'd0};
    return m;
  endfunction

  localparam melody_t REST_MELODY = make_rest_melody();

  typedef struct {
    int off;
    int idx;
    int pitch;
    int tone;
    int ns;
    int busy;
    int done;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];

  melody_sequencer_if sa ();
  melody_sequencer_if sb ();

  melody_sequencer #(
    .TICK_MAXVAL (TICK), .UNIT_SAMPLES (UNIT), .GAP_SAMPLES (GAP), .CNT_W (14)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .seq   (sa)
  );

  melody_sequencer #(
    .TICK_MAXVAL (TICK), .UNIT_SAMPLES (UNIT), .GAP_SAMPLES (GAP), .CNT_W (14),
    .MELODY      (REST_MELODY)
  ) u_rest (
    .clk   (clk),
    .reset (reset),
    .seq   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t v);
    chk($sformatf("t%0d idx", v.off),   int'(sa.note_idx),     v.idx);
    chk($sformatf("t%0d pitch", v.off), int'(sa.pitch_maxval), v.pitch);
    chk($sformatf("t%0d tone", v.off),  int'(sa.tone_en),      v.tone);
    chk($sformatf("t%0d nstart", v.off), int'(sa.note_start),  v.ns);
    chk($sformatf("t%0d busy", v.off),  int'(sa.busy),         v.busy);
    chk($sformatf("t%0d done", v.off),  int'(sa.done),         v.done);
  endtask

  task automatic chk_idle_a(input string name);
    chk({name, " busy"},   int'(sa.busy),       0);
    chk({name, " tone"},   int'(sa.tone_en),    0);
    chk({name, " idx"},    int'(sa.note_idx),   0);
    chk({name, " nstart"}, int'(sa.note_start), 0);
    chk({name, " done"},   int'(sa.done),       0);
  endtask

  // Pulse start on sa; returns at the negedge where offset n after the first note_start is visible.
  task automatic start_a_and_wait(input int n);
    @(negedge clk);
    sa.start = 1'b1;
    @(negedge clk);
    sa.start = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic stop_a();
    @(negedge clk);
    sa.stop = 1'b1;
    @(negedge clk);
    sa.stop = 1'b0;
  endtask

  task automatic run_full(input logic loop);
    int vi;
    int ns_cnt;
    int done_cnt;
    int tone_hi0;
    vi = 0; ns_cnt = 0; done_cnt = 0; tone_hi0 = 0;
    sa.loop_en = loop;
    @(negedge clk);
    sa.start = 1'b1;
    for (int c = 0; c < 520; c++) begin
      @(negedge clk);
      if (c == 0) sa.start = 1'b0;
      ns_cnt   += int'(sa.note_start);
      done_cnt += int'(sa.done);
      if (c < 32 && sa.tone_en) tone_hi0++;
      while (vi < vecs.size() && vecs[vi].off == c) begin
        chk_vec(vecs[vi]);
        vi++;
      end
      if (c == 512) begin
        if (loop) chk_vec('{512, 0, 27, 1, 1, 1, 0});
        else begin
          chk("end done", int'(sa.done), 1);
          chk("end busy", int'(sa.busy), 0);
          chk("end tone", int'(sa.tone_en), 0);
          chk("end idx", int'(sa.note_idx), 0);
          chk("end nstart", int'(sa.note_start), 0);
        end
      end
      if (c == 513 && !loop) chk("done one-shot", int'(sa.done), 0);
      if (c == 40 || c == 300) sa.start = 1'b1;
      else if (c == 41 || c == 301) sa.start = 1'b0;
    end
    chk("note0 tone-high cycles", tone_hi0, 28);
    chk(loop ? "loop nstart count" : "nstart count", ns_cnt, loop ? 21 : 20);
    chk(loop ? "loop done count" : "done count", done_cnt, loop ? 0 : 1);
    if (!loop) begin
      chk("after busy", int'(sa.busy), 0);
      chk("after tone", int'(sa.tone_en), 0);
    end
  endtask

  initial begin
    int dur_tab[20];
    int pit_tab[20];
    int s;
    int tone_hi;
    dur_tab = '{4, 4, 2, 2, 4, 4, 8, 6, 2, 4, 2, 2, 2, 2, 4, 2, 2, 2, 2, 4};
    pit_tab = '{27, 20, 20, 18, 16, 20, 13, 16, 16, 15, 13, 15, 16, 15, 13, 18, 20, 18, 16, 18};
    total = 0;
    bad   = 0;

    // Per note: start cycle, last sounding cycle, first gap cycle.
    s = 0;
    for (int k = 0; k < 20; k++) begin
      int len;
      len = 8 * dur_tab[k];
      vecs.push_back('{s,           k, pit_tab[k], 1, 1, 1, 0});
      vecs.push_back('{s + len - 5, k, pit_tab[k], 1, 0, 1, 0});
      vecs.push_back('{s + len - 4, k, pit_tab[k], 0, 0, 1, 0});
      s += len;
    end

    reset = 1'b1;
    sa.start = 1'b0; sa.stop = 1'b0; sa.loop_en = 1'b0;
    sb.start = 1'b0; sb.stop = 1'b0; sb.loop_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_a("reset");
    chk("reset pitch", int'(sa.pitch_maxval), 0);

    run_full(1'b0);
    run_full(1'b1);
    stop_a();
    @(negedge clk);
    chk_idle_a("loop stopped");

    // Stop in the middle of note 5, then restart.
    start_a_and_wait(138);
    chk("mid note5 idx", int'(sa.note_idx), 5);
    sa.stop = 1'b1;
    @(negedge clk);
    sa.stop = 1'b0;
    chk_idle_a("stop play");
    @(negedge clk);
    chk("stop play no done", int'(sa.done), 0);
    @(negedge clk);
    sa.start = 1'b1;
    @(negedge clk);
    sa.start = 1'b0;
    chk("restart nstart", int'(sa.note_start), 1);
    chk("restart idx", int'(sa.note_idx), 0);
    chk("restart pitch", int'(sa.pitch_maxval), 27);
    chk("restart tone", int'(sa.tone_en), 1);
    stop_a();

    // Stop during the gap of note 0.
    start_a_and_wait(29);
    chk("gap tone", int'(sa.tone_en), 0);
    chk("gap busy", int'(sa.busy), 1);
    sa.stop = 1'b1;
    @(negedge clk);
    sa.stop = 1'b0;
    chk_idle_a("stop gap");

    // start and stop together in IDLE.
    @(negedge clk);
    sa.start = 1'b1; sa.stop = 1'b1;
    @(negedge clk);
    sa.start = 1'b0; sa.stop = 1'b0;
    chk_idle_a("start+stop");
    @(negedge clk);
    chk_idle_a("start+stop later");

    // Rest entry with duration 0 on the second instance.
    @(negedge clk);
    sb.start = 1'b1;
    tone_hi = 0;
    for (int c = 0; c <= 72; c++) begin
      @(negedge clk);
      if (c == 0) sb.start = 1'b0;
      if (c >= 64 && c < 72 && sb.tone_en) tone_hi++;
      if (c == 64) begin
        chk("rest idx", int'(sb.note_idx), 2);
        chk("rest nstart", int'(sb.note_start), 1);
        chk("rest pitch held", int'(sb.pitch_maxval), 20);
        chk("rest busy", int'(sb.busy), 1);
      end
      if (c == 71) chk("rest pitch end", int'(sb.pitch_maxval), 20);
      if (c == 72) begin
        chk("after rest idx", int'(sb.note_idx), 3);
        chk("after rest pitch", int'(sb.pitch_maxval), 18);
        chk("after rest tone", int'(sb.tone_en), 1);
        chk("after rest nstart", int'(sb.note_start), 1);
      end
    end
    chk("rest tone-high cycles", tone_hi, 0);

    // Reset in the middle of a note clears everything.
    start_a_and_wait(10);
    chk("pre-reset busy", int'(sa.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_a("mid reset");
    chk("mid reset pitch", int'(sa.pitch_maxval), 0);
    chk("mid reset b busy", int'(sb.busy), 0);
    chk("mid reset b pitch", int'(sb.pitch_maxval), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
